// File: rtl/matrix_input_parser.sv
// Parses decimal ASCII "m n e0 e1 ..." from a UART byte stream
// and writes each element into storage at base + index.
module matrix_input_parser #(
  parameter int MAX_DIM = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        w_en_input,
  input  logic [8:0]  w_in_base_addr,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        w_storage_we,
  output logic [8:0]  w_storage_waddr,
  output logic [31:0] w_storage_wdata,
  output logic [31:0] o_m,
  output logic [31:0] o_n,
  output logic        w_in_done,
  output logic        w_in_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_GET_M    = 3'd1;
  localparam logic [2:0] S_GET_N    = 3'd2;
  localparam logic [2:0] S_GET_ELEM = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_ERR      = 3'd5;

  logic [2:0]  state;
  logic [31:0] acc;
  logic [31:0] idx;
  logic        digit_seen;

  logic        is_digit;
  logic        is_delim;
  logic [7:0]  digit;
  logic        ovf;
  logic [31:0] acc_next;
  logic        dim_bad;
  logic        last_elem;

  assign is_digit = (i_rx_data >= 8'd48) && (i_rx_data <= 8'd57);
  assign is_delim = (i_rx_data == 8'd32) ||
                    (i_rx_data == 8'd13) ||
                    (i_rx_data == 8'd10);
  assign digit    = i_rx_data - 8'd48;
  // Reject any digit that would push the token past 2^32-1.
  assign ovf      = (acc > 32'd429496729) ||
                    ((acc == 32'd429496729) && (digit > 8'd5));
  assign acc_next = (acc * 32'd10) + {24'd0, digit};
  assign dim_bad  = (acc == 32'd0) || (acc > 32'(MAX_DIM));
  assign last_elem = (idx == ((o_m * o_n) - 32'd1));

  assign w_in_done = (state == S_DONE);
  assign w_in_err  = (state == S_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      acc             <= 32'd0;
      idx             <= 32'd0;
      digit_seen      <= 1'b0;
      w_storage_we    <= 1'b0;
      w_storage_waddr <= 9'd0;
      w_storage_wdata <= 32'd0;
      o_m             <= 32'd0;
      o_n             <= 32'd0;
    end else begin
      w_storage_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (w_en_input) begin
            state      <= S_GET_M;
            acc        <= 32'd0;
            digit_seen <= 1'b0;
            idx        <= 32'd0;
          end
        end
        S_DONE, S_ERR: begin
          if (!w_en_input) state <= S_IDLE;
        end
        S_GET_M, S_GET_N, S_GET_ELEM: begin
          if (!w_en_input) begin
            state <= S_IDLE;
          end else if (i_rx_valid) begin
            unique case (1'b1)
              is_digit: begin
                if (ovf) begin
                  state <= S_ERR;
                end else begin
                  acc        <= acc_next;
                  digit_seen <= 1'b1;
                end
              end
              is_delim: begin
                if (digit_seen) begin
                  acc        <= 32'd0;
                  digit_seen <= 1'b0;
                  if (state == S_GET_M) begin
                    if (dim_bad) state <= S_ERR;
                    else begin
                      o_m   <= acc;
                      state <= S_GET_N;
                    end
                  end else if (state == S_GET_N) begin
                    if (dim_bad) state <= S_ERR;
                    else begin
                      o_n   <= acc;
                      state <= S_GET_ELEM;
                    end
                  end else begin
                    w_storage_we    <= 1'b1;
                    w_storage_waddr <= w_in_base_addr + idx[8:0];
                    w_storage_wdata <= acc;
                    idx             <= idx + 32'd1;
                    if (last_elem) state <= S_DONE;
                  end
                end
              end
              default: state <= S_ERR;
            endcase
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_input_parser.sv
// Scoreboard bench for matrix_input_parser: expected writes are
// queued by the stimulus and popped by a negedge monitor.
module tb_matrix_input_parser;

  logic        clk;
  logic        rst_n;
  logic        w_en_input;
  logic [8:0]  w_in_base_addr;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        w_storage_we;
  logic [8:0]  w_storage_waddr;
  logic [31:0] w_storage_wdata;
  logic [31:0] o_m;
  logic [31:0] o_n;
  logic        w_in_done;
  logic        w_in_err;

  int tests;
  int fails;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  matrix_input_parser #(.MAX_DIM(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .w_en_input      (w_en_input),
    .w_in_base_addr  (w_in_base_addr),
    .i_rx_data       (i_rx_data),
    .i_rx_valid      (i_rx_valid),
    .w_storage_we    (w_storage_we),
    .w_storage_waddr (w_storage_waddr),
    .w_storage_wdata (w_storage_wdata),
    .o_m             (o_m),
    .o_n             (o_n),
    .w_in_done       (w_in_done),
    .w_in_err        (w_in_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (w_storage_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0d data %0h, expected none",
                 w_storage_waddr, w_storage_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("waddr", {23'd0, w_storage_waddr}, {23'd0, e.addr});
        check("wdata", w_storage_wdata, e.data);
      end
    end
  end

  task automatic expect_wr(input logic [8:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      i_rx_data  = s[i];
      i_rx_valid = 1'b1;
    end
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic start(input logic [8:0] base);
    @(negedge clk);
    w_in_base_addr = base;
    w_en_input     = 1'b1;
  endtask

  task automatic stop();
    @(negedge clk);
    w_en_input = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_done", {31'd0, w_in_done}, 32'd0);
    check("idle_err", {31'd0, w_in_err}, 32'd0);
    check("all_writes_seen", exp_q.size(), 32'd0);
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    rst_n          = 1'b0;
    w_en_input     = 1'b0;
    w_in_base_addr = 9'd0;
    i_rx_data      = 8'd0;
    i_rx_valid     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_we", {31'd0, w_storage_we}, 32'd0);
    check("rst_waddr", {23'd0, w_storage_waddr}, 32'd0);
    check("rst_wdata", w_storage_wdata, 32'd0);
    check("rst_m", o_m, 32'd0);
    check("rst_n", o_n, 32'd0);
    check("rst_done", {31'd0, w_in_done}, 32'd0);
    check("rst_err", {31'd0, w_in_err}, 32'd0);
    rst_n = 1'b1;

    // 2x3 matrix, back-to-back bytes
    start(9'd16);
    for (int i = 0; i < 6; i++) expect_wr(9'(16 + i), 32'(i + 1));
    send("2 3\r\n1 2 3\r\n4 5 6 ");
    check("t1_done_with_last_write", {31'd0, w_in_done}, 32'd1);
    repeat (3) @(negedge clk);
    check("t1_done_held", {31'd0, w_in_done}, 32'd1);
    check("t1_m", o_m, 32'd2);
    check("t1_n", o_n, 32'd3);
    stop();

    // max value, leading and repeated delimiters
    start(9'd100);
    expect_wr(9'd100, 32'hFFFF_FFFF);
    send("  1\r\n\r\n1   4294967295 ");
    check("t2_done", {31'd0, w_in_done}, 32'd1);
    stop();

    // overflow by one
    start(9'd0);
    send("1 1 4294967296");
    check("t3_err", {31'd0, w_in_err}, 32'd1);
    stop();

    start(9'd0);
    send("6 2 ");
    check("t4_err_dim_big", {31'd0, w_in_err}, 32'd1);
    stop();

    start(9'd0);
    send("0 ");
    check("t4_err_dim_zero", {31'd0, w_in_err}, 32'd1);
    stop();

    start(9'd0);
    send("2 x");
    check("t4_err_bad_char", {31'd0, w_in_err}, 32'd1);
    stop();

    // abort after two elements, then a clean re-run
    start(9'd40);
    expect_wr(9'd40, 32'd7);
    expect_wr(9'd41, 32'd8);
    send("2 2 7 8 ");
    check("t5_no_done", {31'd0, w_in_done}, 32'd0);
    stop();
    start(9'd40);
    for (int i = 0; i < 4; i++) expect_wr(9'(40 + i), 32'(i + 1));
    send("2 2 1 2 3 4 ");
    check("t5_rerun_done", {31'd0, w_in_done}, 32'd1);
    stop();

    // address wrap
    start(9'd510);
    expect_wr(9'd510, 32'd9);
    expect_wr(9'd511, 32'd8);
    expect_wr(9'd0, 32'd7);
    expect_wr(9'd1, 32'd6);
    send("2 2 9 8 7 6 ");
    check("t6_done", {31'd0, w_in_done}, 32'd1);
    stop();

    // unterminated final token is not committed
    start(9'd8);
    expect_wr(9'd8, 32'd5);
    send("1 2 5 6");
    repeat (3) @(negedge clk);
    check("t7_no_done", {31'd0, w_in_done}, 32'd0);
    stop();

    // reset cancels the write the delimiter would schedule
    start(9'd8);
    send("1 2 7");
    i_rx_data  = 8'd32;
    i_rx_valid = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    i_rx_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("t8_rst_we", {31'd0, w_storage_we}, 32'd0);
    check("t8_rst_m", o_m, 32'd0);
    stop();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
